pixel_frame_streamer: RTL

Transmit side of the network's pixel interface; the receiving end is the network top that consumes pixel/valid and returns a class result.
- A host or camera-capture path loads one IMG_W x IMG_H 8-bit frame into an internal buffer.
- On `start`, the block streams the frame in raster order, one pixel per cycle, into the network's pixel input.
- It then waits for the network's result handshake, latches the class index and flags completion to the host.

---
 rtl/pixel_frame_streamer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/pixel_frame_streamer.sv
// Purpose : buffers one IMG_W x IMG_H frame, streams it in raster order into the
//           network pixel input on start, then latches the returned class index.
// Latency : first pixel_valid 2 cycles after the start edge; N pixels back to back.
//           The network side has no stall: pixels go out one per cycle.
//           The host sees busy, and writes or start issued while busy is high are dropped.
// Ports   : clk/rstn (async active-low); wr_en/wr_addr/wr_data load the buffer;
//           start kicks a frame; pixel_out/pixel_valid feed the network;
//           result_in/result_valid return the class; busy/done/result report status.
// Option  : FEEDER_TIMEOUT_EN adds a WAIT_RES watchdog (TIMEOUT_CYC) that drives timeout.
module pixel_frame_streamer #(
  parameter int IMG_W  = 40,
  parameter int IMG_H  = 40,
  parameter int PIX_W  = 8,
  parameter int RES_W  = 8,
  parameter int ADDR_W = 11
`ifdef FEEDER_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 65535
`endif
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  input  logic              start,
  output logic [PIX_W-1:0]  pixel_out,
  output logic              pixel_valid,
  input  logic [RES_W-1:0]  result_in,
  input  logic              result_valid,
  output logic              busy,
  output logic              done,
  output logic [RES_W-1:0]  result,
  output logic              timeout
);

  localparam int                N    = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);
  localparam logic [ADDR_W:0]   NUM  = (ADDR_W + 1)'(N);

  typedef enum logic [1:0] {IDLE, STREAM, WAIT_RES, FINISH} state_t;

  state_t            state;
  logic [PIX_W-1:0]  mem [N];
  logic [PIX_W-1:0]  rd_data;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_vld;    // rd_data holds a freshly read pixel
  logic              rd_done;   // last address has been issued
  logic              res_got;   // a result was already captured this frame
  logic              rd_issue;
  logic              wr_ok;

`ifdef FEEDER_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);
  logic [15:0] wd_cnt;
`else
  assign timeout = 1'b0;
`endif

  assign rd_issue = (state == STREAM) && !rd_done;
  // Extra MSB on the compare so a buffer of exactly 2**ADDR_W entries still works.
  assign wr_ok    = wr_en && !busy && ({1'b0, wr_addr} < NUM);

  // Frame buffer: no reset, contents survive rstn.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_issue) begin
      rd_data <= mem[rd_addr];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      pixel_out   <= '0;
      pixel_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      rd_addr     <= '0;
      rd_vld      <= 1'b0;
      rd_done     <= 1'b0;
      res_got     <= 1'b0;
`ifdef FEEDER_TIMEOUT_EN
      timeout     <= 1'b0;
      wd_cnt      <= '0;
`endif
    end else begin
      // Output stage: one register behind the buffer read; holds the last pixel.
      pixel_valid <= rd_vld;
      if (rd_vld) begin
        pixel_out <= rd_data;
      end
      rd_vld <= rd_issue;

      case (state)
        IDLE: begin
          if (start) begin
            state   <= STREAM;
            busy    <= 1'b1;
            rd_addr <= '0;
            rd_done <= 1'b0;
            res_got <= 1'b0;
`ifdef FEEDER_TIMEOUT_EN
            timeout <= 1'b0;
`endif
          end
        end

        STREAM: begin
          if (!rd_done) begin
            // Stop at the terminal count rather than wrapping.
            if (rd_addr == LAST) begin
              rd_done <= 1'b1;
            end else begin
              rd_addr <= rd_addr + 1'b1;
            end
          end
          if (result_valid && !res_got) begin
            result  <= result_in;
            res_got <= 1'b1;
          end
          // Leave only once the read pipeline has drained, so busy covers every pixel.
          if (rd_done && !rd_vld) begin
            if (res_got || result_valid) begin
              state <= FINISH;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= WAIT_RES;
`ifdef FEEDER_TIMEOUT_EN
              wd_cnt <= '0;
`endif
            end
          end
        end

        WAIT_RES: begin
          if (result_valid) begin
            result  <= result_in;
            res_got <= 1'b1;
            state   <= FINISH;
            done    <= 1'b1;
            busy    <= 1'b0;
          end
`ifdef FEEDER_TIMEOUT_EN
          else if (wd_cnt == TO_LAST) begin
            timeout <= 1'b1;
            state   <= FINISH;
            done    <= 1'b1;
            busy    <= 1'b0;
          end else begin
            wd_cnt <= wd_cnt + 16'd1;
          end
`endif
        end

        FINISH: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
